instruction_phase_sequencer: RTL
================================

Name: instruction_phase_sequencer

Overview:
Parametrised next-generation phase sequencer for the CPU core. It generates a one-hot phase vector of configurable length for the instruction sequencers and latches the instruction word in a configurable phase. It adds wait-state stalling, a PC breakpoint comparator and multi-instruction debug stepping over a four-phase REQ/ACK handshake. It sits between the bus/debug interface and the sequencers, in the same position as the current fixed four-phase decoder.

Parameters:
DATA_W, 16, instruction/data bus width
ADDR_W, 16, PC and breakpoint address width
NPHASES, 4, phases per instruction (legal range >=2; phase 0 = fetch)
LATCH_PHASE, 2, phase index in which INSTRUCTION captures DIN (must be < NPHASES)
STEP_W, 8, width of the step counter

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
DEBUG_STOPX  in  1  request debug stop at the next instruction boundary
DEBUG_STEP_REQ  in  1  step request (four-phase handshake)
STEP_COUNT  in  STEP_W  instructions per step request (0 treated as 1)
HALTX  in  1  1 = hold in STOPPED / disable PC
WAIT  in  1  stall: hold the current phase
BP_EN  in  1  breakpoint enable
BP_ADDR  in  ADDR_W  breakpoint address
PC  in  ADDR_W  current program counter
DIN  in  DATA_W  instruction bus
PHASE  out  NPHASES  one-hot phase, all zero when not running
STOPPED  out  1  sequencer idle
DEBUG_ACTIVE  out  1  in any debug state
DEBUG_STEP_ACK  out  1  step complete
BP_HIT  out  1  last stop caused by the breakpoint
PC_ENX  out  1  PC advance enable (active high)
INSTRUCTION  out  DATA_W  latched instruction
STEPS_LEFT  out  STEP_W  remaining steps in the current request

Behaviour:
- The block uses a state register plus a phase index PH (0..NPHASES-1). States: ST_STOP, ST_RUN, ST_DSTOP, ST_DRUN, ST_DACK.
- All outputs are registered. Each output reflects the state/PH entered on that edge, computed from the next-state logic.
- Reset values: state ST_STOP, PH=0, PHASE=0, STOPPED=1, DEBUG_ACTIVE=0, DEBUG_STEP_ACK=0, BP_HIT=0, PC_ENX=0, INSTRUCTION=0, STEPS_LEFT=0. Reset asserted mid-operation aborts immediately to these values.
- Breakpoint match "bp" = BP_EN && PC==BP_ADDR, sampled on the clock edge that would enter PH=0.
- Boundary = a RUN/DRUN cycle with PH=NPHASES-1 and WAIT=0.
- ST_STOP transitions, in priority order:
  - DEBUG_STOPX=1 -> ST_DSTOP.
  - HALTX=0 and bp -> ST_DSTOP with BP_HIT=1.
  - HALTX=0 -> ST_RUN, PH=0.
  - Otherwise hold.
- ST_RUN:
  - WAIT=1 holds PH.
  - Otherwise PH increments.
  - At a boundary: DEBUG_STOPX -> ST_DSTOP; else bp -> ST_DSTOP with BP_HIT=1; else PH=0 (continue).
  - HALTX does not stop a running sequence; it only deasserts PC_ENX.
- ST_DSTOP:
  - DEBUG_STEP_REQ=1 -> ST_DRUN, PH=0, STEPS_LEFT=max(STEP_COUNT,1), BP_HIT cleared.
  - Else DEBUG_STOPX=0 -> ST_STOP, BP_HIT cleared.
  - Else hold.
- ST_DRUN:
  - Phases advance as in RUN (WAIT honoured).
  - At a boundary STEPS_LEFT decrements. If the result is 0 -> ST_DACK.
  - Else if bp -> ST_DACK with BP_HIT=1, STEPS_LEFT keeps the remainder.
  - Else PH=0 and continue.
  - The breakpoint is never checked for the first instruction of a request, so a step always leaves a breakpointed PC.
  - DEBUG_STOPX changes are ignored in ST_DRUN.
- ST_DACK:
  - DEBUG_STEP_ACK=1 for the whole state.
  - DEBUG_STEP_REQ=0 -> ST_DSTOP.
- STOPPED = state in {ST_STOP, ST_DSTOP, ST_DACK}.
- DEBUG_ACTIVE = state in {ST_DSTOP, ST_DRUN, ST_DACK}.
- PHASE[i] = 1 iff state in {ST_RUN, ST_DRUN} and PH==i.
- PC_ENX = (next state ST_RUN and HALTX=0) or next state ST_DRUN.
- INSTRUCTION captures DIN on the negedge of CLK while PHASE[LATCH_PHASE]=1. Under WAIT it re-captures on every such negedge, so the last capture wins. It is reset asynchronously to 0.
- Width rules:
  - STEPS_LEFT decrement never wraps below 0.
  - STEP_COUNT=0 loads 1.
  - BP comparison is a full ADDR_W equality.

Test Plan:
1. Free run with NPHASES=4: release RESET, HALTX=0 -> PHASE sequence 0001,0010,0100,1000,0001… from the first edge; PC_ENX=1; DIN=16'hA5C3 during phase 2 -> INSTRUCTION=16'hA5C3 by the phase 2 negedge.
2. WAIT: assert WAIT for 3 cycles during phase 1 -> PHASE holds 0010 for 4 cycles, then 0100; no phase is skipped.
3. Debug stop: assert DEBUG_STOPX mid-phase 1 -> current instruction completes. After phase 3, STOPPED=1, DEBUG_ACTIVE=1, PHASE=0. Deassert DEBUG_STOPX -> ST_STOP, DEBUG_ACTIVE=0 next edge, then RUN resumes.
4. Multi-step: in ST_DSTOP, STEP_COUNT=3, pulse REQ high and hold -> exactly 12 phase cycles, then DEBUG_STEP_ACK=1, STEPS_LEFT=0. ACK stays high until REQ=0, then drops one edge later. STEP_COUNT=0 gives exactly 4 phase cycles.
5. Breakpoint: BP_EN=1, BP_ADDR=16'h0040, PC reaches 16'h0040 at a RUN boundary -> ST_DSTOP with BP_HIT=1, no fetch phase issued. A one-step request executes that instruction (4 phases) and clears BP_HIT on entry. A step of 5 hitting the BP after 2 instructions -> DACK with BP_HIT=1, STEPS_LEFT=3.
6. Reset mid-phase 2 with WAIT=1 -> all outputs return to reset values asynchronously; INSTRUCTION=0.

Source files
------------

// File: rtl/instruction_phase_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_phase_sequencer
//
// Generates a one-hot phase vector of NPHASES phases per instruction for the
// instruction sequencers and latches the instruction word from the bus in
// phase LATCH_PHASE. It also provides:
//   - wait-state stalling (WAIT holds the current phase),
//   - a PC breakpoint comparator checked at instruction boundaries,
//   - multi-instruction debug stepping over a four-phase REQ/ACK handshake.
//
// Ports:
//   CLK             clock
//   RESET           asynchronous, active-high reset
//   DEBUG_STOPX     request a debug stop at the next instruction boundary
//   DEBUG_STEP_REQ  step request (four-phase handshake with DEBUG_STEP_ACK)
//   STEP_COUNT      instructions per step request (0 behaves as 1)
//   HALTX           1 = hold in STOPPED / disable PC advance
//   WAIT            stall, hold the current phase
//   BP_EN           breakpoint enable
//   BP_ADDR         breakpoint address
//   PC              current program counter
//   DIN             instruction bus
//   PHASE           one-hot phase, all zero when not running
//   STOPPED         sequencer idle (stop, debug stop or step acknowledge)
//   DEBUG_ACTIVE    in any debug state
//   DEBUG_STEP_ACK  step request complete
//   BP_HIT          last stop was caused by the breakpoint
//   PC_ENX          PC advance enable (active high)
//   INSTRUCTION     latched instruction word
//   STEPS_LEFT      remaining steps in the current step request
//
// All control outputs are registered and reflect the state/phase entered on
// the same clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_phase_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NPHASES     = 4,
    parameter int LATCH_PHASE = 2,
    parameter int STEP_W      = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DEBUG_STOPX,
    input  logic              DEBUG_STEP_REQ,
    input  logic [STEP_W-1:0] STEP_COUNT,
    input  logic              HALTX,
    input  logic              WAIT,
    input  logic              BP_EN,
    input  logic [ADDR_W-1:0] BP_ADDR,
    input  logic [ADDR_W-1:0] PC,
    input  logic [DATA_W-1:0] DIN,
    output logic [NPHASES-1:0] PHASE,
    output logic              STOPPED,
    output logic              DEBUG_ACTIVE,
    output logic              DEBUG_STEP_ACK,
    output logic              BP_HIT,
    output logic              PC_ENX,
    output logic [DATA_W-1:0] INSTRUCTION,
    output logic [STEP_W-1:0] STEPS_LEFT
);

    localparam int              PH_W    = (NPHASES > 1) ? $clog2(NPHASES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASES - 1);
    localparam logic [PH_W-1:0] PH_ZERO = '0;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DSTOP = 3'd2,
        ST_DRUN  = 3'd3,
        ST_DACK  = 3'd4
    } state_t;

    // Step counter arithmetic: decrement saturates at zero, a zero request
    // count still executes one instruction.
    function automatic logic [STEP_W-1:0] sat_dec(input logic [STEP_W-1:0] v);
        return (v == '0) ? v : v - STEP_W'(1);
    endfunction

    function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] v);
        return (v == '0) ? STEP_W'(1) : v;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PH_W-1:0]     r_ph;
    logic [PH_W-1:0]     w_ph_nxt;
    logic [PH_W-1:0]     w_ph_adv;
    logic [STEP_W-1:0]   r_steps_left;
    logic [STEP_W-1:0]   w_steps_nxt;
    logic [STEP_W-1:0]   w_steps_dec;
    logic                r_bp_hit;
    logic                w_bp_hit_nxt;
    logic                w_bp;
    logic                w_running;
    logic                w_boundary;
    logic                w_run_nxt;
    logic [NPHASES-1:0]  w_phase_nxt;
    logic [NPHASES-1:0]  r_phase;
    logic                r_stopped;
    logic                r_debug_active;
    logic                r_step_ack;
    logic                r_pc_enx;
    logic [DATA_W-1:0]   r_instruction;

    assign w_bp        = BP_EN && (PC == BP_ADDR);
    assign w_running   = (r_state == ST_RUN) || (r_state == ST_DRUN);
    assign w_boundary  = w_running && (r_ph == PH_LAST) && !WAIT;
    // Phase wraps to 0 after the last phase; a stall holds the current one.
    assign w_ph_adv    = WAIT ? r_ph :
                         ((r_ph == PH_LAST) ? PH_ZERO : r_ph + PH_W'(1));
    assign w_steps_dec = sat_dec(r_steps_left);

    always_comb begin
        w_state_nxt  = r_state;
        w_ph_nxt     = r_ph;
        w_steps_nxt  = r_steps_left;
        w_bp_hit_nxt = r_bp_hit;

        case (r_state)
            ST_STOP: begin
                w_ph_nxt = PH_ZERO;
                if (DEBUG_STOPX) begin
                    w_state_nxt = ST_DSTOP;
                end else if (!HALTX && w_bp) begin
                    w_state_nxt  = ST_DSTOP;
                    w_bp_hit_nxt = 1'b1;
                end else if (!HALTX) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                w_ph_nxt = w_ph_adv;
                if (w_boundary) begin
                    if (DEBUG_STOPX) begin
                        w_state_nxt = ST_DSTOP;
                    end else if (w_bp) begin
                        w_state_nxt  = ST_DSTOP;
                        w_bp_hit_nxt = 1'b1;
                    end
                end
            end

            ST_DSTOP: begin
                w_ph_nxt = PH_ZERO;
                if (DEBUG_STEP_REQ) begin
                    w_state_nxt  = ST_DRUN;
                    w_steps_nxt  = step_load(STEP_COUNT);
                    w_bp_hit_nxt = 1'b0;
                end else if (!DEBUG_STOPX) begin
                    w_state_nxt  = ST_STOP;
                    w_bp_hit_nxt = 1'b0;
                end
            end

            ST_DRUN: begin
                w_ph_nxt = w_ph_adv;
                // The breakpoint is only evaluated once at least one step
                // remains, so the first instruction of a request always
                // executes even when it sits on the breakpoint address.
                if (w_boundary) begin
                    w_steps_nxt = w_steps_dec;
                    if (w_steps_dec == '0) begin
                        w_state_nxt = ST_DACK;
                    end else if (w_bp) begin
                        w_state_nxt  = ST_DACK;
                        w_bp_hit_nxt = 1'b1;
                    end
                end
            end

            ST_DACK: begin
                w_ph_nxt = PH_ZERO;
                if (!DEBUG_STEP_REQ) begin
                    w_state_nxt = ST_DSTOP;
                end
            end

            default: begin
                w_state_nxt = ST_STOP;
                w_ph_nxt    = PH_ZERO;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRUN);

    always_comb begin
        w_phase_nxt = '0;
        for (int i = 0; i < NPHASES; i++) begin
            w_phase_nxt[i] = w_run_nxt && (w_ph_nxt == PH_W'(i));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_STOP;
            r_ph           <= PH_ZERO;
            r_steps_left   <= '0;
            r_bp_hit       <= 1'b0;
            r_phase        <= '0;
            r_stopped      <= 1'b1;
            r_debug_active <= 1'b0;
            r_step_ack     <= 1'b0;
            r_pc_enx       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ph           <= w_ph_nxt;
            r_steps_left   <= w_steps_nxt;
            r_bp_hit       <= w_bp_hit_nxt;
            r_phase        <= w_phase_nxt;
            r_stopped      <= (w_state_nxt == ST_STOP) || (w_state_nxt == ST_DSTOP) ||
                              (w_state_nxt == ST_DACK);
            r_debug_active <= (w_state_nxt == ST_DSTOP) || (w_state_nxt == ST_DRUN) ||
                              (w_state_nxt == ST_DACK);
            r_step_ack     <= (w_state_nxt == ST_DACK);
            r_pc_enx       <= ((w_state_nxt == ST_RUN) && !HALTX) || (w_state_nxt == ST_DRUN);
        end
    end

    // Instruction is captured mid-cycle so the bus has the full first half of
    // the latch phase to settle; a stalled latch phase keeps re-capturing and
    // the last value seen wins.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            r_instruction <= '0;
        end else if (r_phase[LATCH_PHASE]) begin
            r_instruction <= DIN;
        end
    end

    assign PHASE          = r_phase;
    assign STOPPED        = r_stopped;
    assign DEBUG_ACTIVE   = r_debug_active;
    assign DEBUG_STEP_ACK = r_step_ack;
    assign BP_HIT         = r_bp_hit;
    assign PC_ENX         = r_pc_enx;
    assign INSTRUCTION    = r_instruction;
    assign STEPS_LEFT     = r_steps_left;

endmodule
